// File: rtl/regfile_wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter_pkg
//   Shared core constants and small types used by the writeback arbiter and
//   any other block that needs the core data/register widths.
//
//   Contents:
//     CORE_XLEN      data width of writeback values
//     CORE_REG_AW    register address width
//     CORE_NUM_REGS  number of architectural registers (2**CORE_REG_AW)
//     grant_e        identity of the requester that won the last transfer
// ---------------------------------------------------------------------------
package regfile_wb_arbiter_pkg;

    localparam int CORE_XLEN     = 32;
    localparam int CORE_REG_AW   = 5;
    localparam int CORE_NUM_REGS = 2 ** CORE_REG_AW;

    // Requester that completed the most recent transfer.
    typedef enum logic {
        GRANT_REQ0 = 1'b0,
        GRANT_REQ1 = 1'b1
    } grant_e;

endpackage : regfile_wb_arbiter_pkg

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
//   Two-way round-robin grant for a shared single-ported resource.
//   A grant is only ever raised for a requester whose valid is high, and at
//   most one grant is high per cycle. When both request, the one that did not
//   win the last transfer is granted, so sustained contention alternates.
//   Grants are combinational; only the last-winner state is registered.
//
//   Ports:
//     clk     in   clock
//     reset   in   synchronous, active-high; last winner becomes requester 1
//                  so requester 0 wins the first tie
//     valid0  in   requester 0 is requesting
//     valid1  in   requester 1 is requesting
//     grant0  out  requester 0 granted this cycle (a transfer happens)
//     grant1  out  requester 1 granted this cycle (a transfer happens)
// ---------------------------------------------------------------------------
module rr_arbiter2
    import regfile_wb_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic valid0,
    input  logic valid1,
    output logic grant0,
    output logic grant1
);

    grant_e last_grant;

    always_comb begin
        grant0 = valid0 && (!valid1 || (last_grant == GRANT_REQ1));
        grant1 = valid1 && (!valid0 || (last_grant == GRANT_REQ0));
    end

    // A grant is always a transfer (grant implies valid), so the winner
    // recorded here is exactly the last requester that moved data.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= GRANT_REQ1;
        end else if (grant0) begin
            last_grant <= GRANT_REQ0;
        end else if (grant1) begin
            last_grant <= GRANT_REQ1;
        end
    end

endmodule : rr_arbiter2

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//   Shares the register file's single write port between two writeback
//   requesters (req0: ALU/pipeline, req1: multi-cycle unit) and keeps a
//   pending-write scoreboard so decode can stall on operands still in flight.
//
//   Handshake (both requesters): a transfer happens in a cycle where
//   valid && ready. A requester that raises valid holds valid, rd and data
//   stable until it sees ready. ready is combinational from both valids and
//   the arbiter's last winner; it is never high without its own valid and
//   never high for both requesters in the same cycle. Nothing is buffered:
//   a requester that is not granted simply waits.
//
//   Ports:
//     clk, reset                   clock, synchronous active-high reset
//     req0_valid/rd/data, _ready   requester 0 writeback handshake
//     req1_valid/rd/data, _ready   requester 1 writeback handshake
//     issue_valid, issue_rd        decode issued an instruction writing rd
//     rs1_addr, rs2_addr           decode source operands
//     rs1_busy, rs2_busy           source operand has a write not yet landed
//     address_dest, data_dest,
//     write_dest                   registered register-file write port
// ---------------------------------------------------------------------------
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int XLEN   = CORE_XLEN,
    parameter int REG_AW = CORE_REG_AW
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_valid,
    input  logic [REG_AW-1:0] req0_rd,
    input  logic [XLEN-1:0]   req0_data,
    output logic              req0_ready,

    input  logic              req1_valid,
    input  logic [REG_AW-1:0] req1_rd,
    input  logic [XLEN-1:0]   req1_data,
    output logic              req1_ready,

    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    output logic              rs1_busy,
    output logic              rs2_busy,

    output logic [REG_AW-1:0] address_dest,
    output logic [XLEN-1:0]   data_dest,
    output logic              write_dest
);

    localparam int NUM_REGS = 2 ** REG_AW;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic grant0;
    logic grant1;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    logic              xfer;
    logic [REG_AW-1:0] sel_rd;
    logic [XLEN-1:0]   sel_data;

    always_comb begin
        xfer     = grant0 || grant1;
        sel_rd   = grant1 ? req1_rd   : req0_rd;
        sel_data = grant1 ? req1_data : req0_data;
    end

    // ------------------------------------------------------------------
    // Registered write port: loaded on the transfer edge, the register
    // file commits it on the following edge. Writes to x0 are accepted
    // but never enabled. Address/data keep their value between transfers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            write_dest   <= 1'b0;
            address_dest <= '0;
            data_dest    <= '0;
        end else if (xfer) begin
            write_dest   <= (sel_rd != '0);
            address_dest <= sel_rd;
            data_dest    <= sel_data;
        end else begin
            write_dest   <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Pending-write scoreboard, one bit per register.
    // The clear is tied to write_dest (the edge the register file actually
    // writes), not to the handshake, so busy drops only once the read port
    // shows the new value. The set is applied after the clear so a fresh
    // issue to the same register wins: it is the younger instruction.
    // ------------------------------------------------------------------
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_next;

    always_comb begin
        pending_next = pending;
        if (write_dest) begin
            pending_next[address_dest] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            pending_next[issue_rd] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    assign rs1_busy = pending[rs1_addr];
    assign rs2_busy = pending[rs2_addr];

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//   Directed scenarios followed by randomized traffic. A reference model
//   (spec-level rules over plain arrays) predicts readies, busy flags and the
//   write port; accepted writes are pushed into exp_q with the cycle they are
//   due, and a separate monitor pops them whenever write_dest is high.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREGS  = 2 ** REG_AW;
    localparam int W      = 32 + REG_AW + XLEN;   // {due_cycle, rd, data}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic              req0_valid, req1_valid;
    logic [REG_AW-1:0] req0_rd, req1_rd;
    logic [XLEN-1:0]   req0_data, req1_data;
    logic              req0_ready, req1_ready;
    logic              issue_valid;
    logic [REG_AW-1:0] issue_rd, rs1_addr, rs2_addr;
    logic              rs1_busy, rs2_busy;
    logic [REG_AW-1:0] address_dest;
    logic [XLEN-1:0]   data_dest;
    logic              write_dest;

    regfile_wb_arbiter #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid   (req0_valid),
        .req0_rd      (req0_rd),
        .req0_data    (req0_data),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_rd      (req1_rd),
        .req1_data    (req1_data),
        .req1_ready   (req1_ready),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy),
        .address_dest (address_dest),
        .data_dest    (data_dest),
        .write_dest   (write_dest)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- scoreboard / model state ----------------
    logic [W-1:0]            exp_q[$];
    logic [REG_AW+XLEN-1:0]  r0_q[$];
    logic [REG_AW+XLEN-1:0]  r1_q[$];

    bit                m_last;          // 1: requester 1 won last transfer
    bit                m_pend[NREGS];
    bit                m_wr_v;          // model: write_dest high this cycle
    logic [REG_AW-1:0] m_wr_rd;
    logic [REG_AW-1:0] m_addr;
    logic [XLEN-1:0]   m_data;
    bit                g0 = 0, g1 = 0;  // model grant for the coming edge

    // Reference model: checks this cycle's outputs, then advances its state
    // to what the next clock edge should produce.
    always @(negedge clk) begin
        bit e0, e1;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   dat;
        e0 = 0; e1 = 0;
        if (req0_valid && req1_valid) begin
            if (m_last) e0 = 1; else e1 = 1;
        end else if (req0_valid) e0 = 1;
        else if (req1_valid) e1 = 1;

        if (reset) begin
            m_last = 1;
            foreach (m_pend[i]) m_pend[i] = 0;
            m_wr_v = 0;
            m_addr = '0;
            m_data = '0;
            g0 = 0; g1 = 0;
        end else begin
            check("req0_ready", req0_ready, e0);
            check("req1_ready", req1_ready, e1);
            check("rs1_busy", rs1_busy, (rs1_addr != 0) && m_pend[rs1_addr]);
            check("rs2_busy", rs2_busy, (rs2_addr != 0) && m_pend[rs2_addr]);
            check("address_dest", address_dest, m_addr);
            check("data_dest", data_dest, m_data);

            if (m_wr_v) m_pend[m_wr_rd] = 0;
            if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1;
            m_wr_v = 0;
            if (e0 || e1) begin
                rd  = e0 ? req0_rd   : req1_rd;
                dat = e0 ? req0_data : req1_data;
                m_last = e1;
                m_addr = rd;
                m_data = dat;
                if (rd != 0) begin
                    m_wr_v  = 1;
                    m_wr_rd = rd;
                    exp_q.push_back({32'(cyc + 1), rd, dat});
                end
            end
            g0 = e0; g1 = e1;
        end
    end

    // Monitor: every enabled register-file write must be the oldest
    // expected write, in the cycle it is due.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (write_dest === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {1'b1, address_dest, data_dest}, '0);
            end else begin
                e = exp_q.pop_front();
                check("write_port", {32'(cyc), address_dest, data_dest}, e);
            end
        end else if (exp_q.size() > 0 && int'(exp_q[0][W-1 -: 32]) <= cyc) begin
            e = exp_q.pop_front();
            check("missed_write", {1'b0, address_dest, data_dest}, {1'b1, e[REG_AW+XLEN-1:0]});
        end
    end

    // ---------------- requester drivers ----------------
    // Hold valid/rd/data until the transfer edge, then take the next item.
    initial begin
        req0_valid = 0; req0_rd = '0; req0_data = '0;
        forever begin
            @(posedge clk); #1;
            if (req0_valid && g0) req0_valid = 0;
            if (!req0_valid && r0_q.size() > 0) begin
                {req0_rd, req0_data} = r0_q.pop_front();
                req0_valid = 1;
            end
        end
    end

    initial begin
        req1_valid = 0; req1_rd = '0; req1_data = '0;
        forever begin
            @(posedge clk); #1;
            if (req1_valid && g1) req1_valid = 0;
            if (!req1_valid && r1_q.size() > 0) begin
                {req1_rd, req1_data} = r1_q.pop_front();
                req1_valid = 1;
            end
        end
    end

    // ---------------- main sequence ----------------
    task automatic cycle();
        @(posedge clk); #2;
    endtask

    task automatic do_reset();
        reset = 1;
        issue_valid = 0;
        repeat (2) cycle();
        reset = 0;
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 0;
        for (int i = 0; i < 200; i++) begin
            if (r0_q.size() == 0 && r1_q.size() == 0 && !req0_valid && !req1_valid) begin
                idle = 1;
                break;
            end
            cycle();
        end
        check("drain_timeout", idle, 1'b1);
        repeat (3) cycle();
    endtask

    initial begin
        reset = 1; issue_valid = 0; issue_rd = '0; rs1_addr = '0; rs2_addr = '0;
        repeat (3) cycle();
        reset = 0;

        // single req0 write after reset
        rs1_addr = 5;
        r0_q.push_back({5'd5, 32'hDEADBEEF});
        wait_idle();

        // contention from reset: expect 1,11,2,12,3,13,4,14
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            r0_q.push_back({5'(i), 32'(32'h100 + i)});
            r1_q.push_back({5'(i + 10), 32'(32'h200 + i)});
        end
        wait_idle();

        // issue rd=7, req1 writes rd=7 three cycles later
        rs1_addr = 7;
        issue_valid = 1; issue_rd = 7;
        cycle();
        issue_valid = 0;
        repeat (2) cycle();
        r1_q.push_back({5'd7, 32'hCAFE0007});
        wait_idle();

        // re-issue rd=9 while the rd=9 write lands: stays pending
        rs2_addr = 9;
        issue_valid = 1; issue_rd = 9;
        cycle();
        r0_q.push_back({5'd9, 32'h99});
        repeat (4) cycle();
        issue_valid = 0;
        repeat (2) cycle();
        r0_q.push_back({5'd9, 32'h9A});
        wait_idle();

        // x0 write and x0 issue
        rs1_addr = 0;
        issue_valid = 1; issue_rd = 0;
        r0_q.push_back({5'd0, 32'h1234});
        cycle();
        issue_valid = 0;
        wait_idle();

        // reset in the cycle after a transfer
        rs1_addr = 20;
        issue_valid = 1; issue_rd = 20;
        cycle();
        issue_valid = 0;
        r0_q.push_back({5'd3, 32'h33333333});
        for (int i = 0; i < 10 && !req0_valid; i++) cycle();
        check("reset_test_valid", req0_valid, 1'b1);
        cycle();
        do_reset();
        r1_q.push_back({5'd22, 32'h22});
        r0_q.push_back({5'd21, 32'h21});
        wait_idle();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            if (r0_q.size() < 2 && $urandom_range(0, 2) != 0)
                r0_q.push_back({5'($urandom_range(0, NREGS - 1)), 32'($urandom)});
            if (r1_q.size() < 2 && $urandom_range(0, 2) != 0)
                r1_q.push_back({5'($urandom_range(0, NREGS - 1)), 32'($urandom)});
            issue_valid = 1'($urandom_range(0, 1));
            issue_rd    = 5'($urandom_range(0, NREGS - 1));
            rs1_addr    = 5'($urandom_range(0, NREGS - 1));
            rs2_addr    = 5'($urandom_range(0, NREGS - 1));
            cycle();
        end
        issue_valid = 0;
        wait_idle();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule : tb_regfile_wb_arbiter

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (address_dest/data_dest/write_dest) between two writeback requesters: req0 is the ALU/pipeline writeback, req1 is the multi-cycle unit (load/mul-div).
- Uses a round-robin valid/ready handshake and drives a registered write port.
- Keeps a pending-register scoreboard so the decode stage can stall on operands whose write has not yet landed.

Parameters:
- XLEN, 32, data width of writeback values.
- REG_AW, 5, register address width; the scoreboard holds 2**REG_AW bits.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has a writeback.
- req0_rd  in  REG_AW  destination register for req0.
- req0_data  in  XLEN  writeback value for req0.
- req0_ready  out  1  req0 is accepted this cycle.
- req1_valid, req1_rd, req1_data, req1_ready  same as req0, for requester 1.
- issue_valid  in  1  decode issues an instruction that will write a register.
- issue_rd  in  REG_AW  destination of the issued instruction.
- rs1_addr  in  REG_AW  decode source operand 1.
- rs2_addr  in  REG_AW  decode source operand 2.
- rs1_busy  out  1  rs1 has a pending write.
- rs2_busy  out  1  rs2 has a pending write.
- address_dest  out  REG_AW  register file write address.
- data_dest  out  XLEN  register file write data.
- write_dest  out  1  register file write enable.

Behaviour:
- Reset (synchronous, active-high, sampled at posedge clk):
  - All pending bits cleared.
  - write_dest=0, address_dest=0, data_dest=0.
  - last_grant=1, so req0 wins the first tie.
  - Reset mid-operation drops any accepted-but-unwritten entry: write_dest is 0 in the cycle after the reset edge.
- Handshake:
  - A transfer occurs when valid && ready.
  - Once a requester asserts valid, it holds valid, rd and data stable until ready.
  - readyN is combinational from the valids and last_grant. At most one ready is high per cycle. No ready is raised without the matching valid.
- Arbitration:
  - Only req0 valid: grant 0. Only req1 valid: grant 1.
  - Both valid: grant the requester other than last_grant.
  - last_grant updates only on a transfer.
  - Result: under continuous contention, grants strictly alternate 0,1,0,1…
- Write port (registered, latency 1):
  - On a transfer at edge N, address_dest, data_dest and write_dest are loaded at edge N.
  - The register file writes at edge N+1.
  - write_dest = 1 only if the accepted rd != 0. An rd==0 request is still accepted (ready high) but produces write_dest=0.
  - With no transfer, write_dest is 0 next cycle. address_dest and data_dest hold their last value.
  - Sustained throughput is one write per cycle.
- Scoreboard, pending[2**REG_AW] (bit 0 is hard-wired 0):
  - Set: issue_valid && issue_rd!=0 sets pending[issue_rd] at the next edge.
  - Clear: write_dest==1 clears pending[address_dest] at the next edge, i.e. when the register file write lands.
  - Same register set and cleared in the same cycle: set wins, because the new issue is younger.
  - rsN_busy = pending[rsN_addr], combinational from the registered vector. It is always 0 for x0.
  - No bypass: busy falls the cycle after the register file write, when the read port already shows the new value.
  - Multiple in-flight writes to one rd are not tracked: one bit per register. Decode must not issue a second writer to an rd while it is busy.
- No internal buffering: a requester stalls while it is not granted.

Decomposition:
- Shared core package gets XLEN and REG_AW, alongside the existing core constants.
- One natural sub-module: rr_arbiter2, a 2-way round-robin grant with last_grant state. It is reusable for other shared core resources.
- The scoreboard stays inline.

Test Plan:
- After reset: req0 rd=5 data=0xDEADBEEF, req1 idle → req0_ready=1 in cycle 0; cycle 1 shows write_dest=1, address_dest=5, data_dest=0xDEADBEEF; cycle 2 shows write_dest=0.
- Both valid for 4 cycles (req0 rd=1..4, req1 rd=11..14) → grants 0,1,0,1; write sequence 1,11,2,12; each loser's payload held stable while it is stalled.
- issue rd=7, then req1 writes rd=7 three cycles later → rs1_busy (rs1_addr=7) is 1 from the cycle after issue through the write_dest cycle; 0 the cycle after.
- Same-cycle issue_rd=9 and write_dest=1 with address_dest=9 → pending[9] remains 1.
- req0 rd=0 data=0x1234 and issue_rd=0 → req0_ready=1, write_dest stays 0, rs1_busy for rs1_addr=0 stays 0.
- Reset asserted in the cycle after a transfer → write_dest=0 and all busy=0 after the edge; the first later contention goes to req0.
